// File: rtl/line_stream_gen.sv
// line_stream_gen: turns one raster word stream into three column-aligned line streams.
// Top-border replication of row 0 is enabled by defining LINE_GEN_REPLICATE_EN.
module line_stream_gen #(
  parameter int LINE_WORDS  = 64,
  parameter int FRAME_LINES = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_data_valid,
  input  logic [63:0] i_pix_data,
  output logic        o_pix_data_ack,
  output logic        o_line1_data_valid,
  output logic [63:0] o_line1_data,
  input  logic        i_line1_data_ack,
  output logic        o_line2_data_valid,
  output logic [63:0] o_line2_data,
  input  logic        i_line2_data_ack,
  output logic        o_line3_data_valid,
  output logic [63:0] o_line3_data,
  input  logic        i_line3_data_ack,
  output logic        o_frame_done
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam int RW = $clog2(FRAME_LINES);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);
`ifdef LINE_GEN_REPLICATE_EN
  localparam logic [RW-1:0] FILL_LAST = RW'(0);
`else
  localparam logic [RW-1:0] FILL_LAST = RW'(1);
`endif

  typedef enum logic {
    ST_FILL,
    ST_STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [63:0]   buf_a_q [LINE_WORDS];
  logic [63:0]   buf_b_q [LINE_WORDS];
  logic [63:0]   rd_a, rd_b;

  logic          out_valid_q, out_valid_d;
  logic [2:0]    done_q, done_d;
  logic [63:0]   l1_q, l1_d;
  logic [63:0]   l2_q, l2_d;
  logic [63:0]   l3_q, l3_d;

  logic [2:0]    acks;
  logic          all_done;
  logic          slot_free;
  logic          accept;
  logic          col_end;
  logic          frame_end;
  logic          fill_end;

  assign acks      = {i_line3_data_ack, i_line2_data_ack, i_line1_data_ack};
  // A line acked earlier stays counted; the slot frees on the last outstanding ack.
  assign all_done  = &(done_q | acks);
  assign slot_free = ~out_valid_q | all_done;

  assign o_pix_data_ack = ~i_rst & (slot_free | (state_q == ST_FILL));
  assign accept         = i_pix_data_valid & o_pix_data_ack;

  assign col_end   = (col_q == COL_LAST);
  assign frame_end = col_end & (row_q == ROW_LAST);
  assign fill_end  = col_end & (row_q == FILL_LAST);

  assign rd_a = buf_a_q[col_q];
  assign rd_b = buf_b_q[col_q];

  // Line buffers: read-before-write shift of the column through bufB -> bufA.
  always_ff @(posedge i_clk) begin
    if (accept) begin
`ifdef LINE_GEN_REPLICATE_EN
      buf_a_q[col_q] <= (state_q == ST_FILL) ? i_pix_data : rd_b;
`else
      buf_a_q[col_q] <= rd_b;
`endif
      buf_b_q[col_q] <= i_pix_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FILL;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      l3_q        <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      l3_q        <= l3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (frame_end) begin
        row_d = '0;
      end else if (col_end) begin
        row_d = row_q + 1'b1;
      end
      case (state_q)
        ST_FILL:   if (fill_end)  state_d = ST_STREAM;
        ST_STREAM: if (frame_end) state_d = ST_FILL;
        default:   state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    done_d      = done_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    l3_d        = l3_q;
    if (accept && (state_q == ST_STREAM)) begin
      out_valid_d = 1'b1;
      done_d      = '0;
      l1_d        = rd_a;
      l2_d        = rd_b;
      l3_d        = i_pix_data;
    end else if (out_valid_q) begin
      if (all_done) begin
        out_valid_d = 1'b0;
        done_d      = '0;
      end else begin
        done_d = done_q | acks;
      end
    end
  end

  assign o_line1_data_valid = out_valid_q;
  assign o_line2_data_valid = out_valid_q;
  assign o_line3_data_valid = out_valid_q;
  assign o_line1_data       = l1_q;
  assign o_line2_data       = l2_q;
  assign o_line3_data       = l3_q;
  assign o_frame_done       = accept & frame_end;

endmodule

// File: tb/tb_line_stream_gen.sv
// Bench for line_stream_gen: frame-level reference model of rows/columns plus a beat scoreboard.
module tb_line_stream_gen;

  localparam int LW = 4;
  localparam int FL = 4;
`ifdef LINE_GEN_REPLICATE_EN
  localparam int FILL_ROWS = 1;
  localparam logic [7:0] FIRST_L1 = 8'h00;
  localparam logic [7:0] FIRST_L2 = 8'h00;
  localparam logic [7:0] FIRST_L3 = 8'h10;
`else
  localparam int FILL_ROWS = 2;
  localparam logic [7:0] FIRST_L1 = 8'h00;
  localparam logic [7:0] FIRST_L2 = 8'h10;
  localparam logic [7:0] FIRST_L3 = 8'h20;
`endif
  localparam int BEATS_PER_FRAME = LW * (FL - FILL_ROWS);

  logic        clk;
  logic        i_rst;
  logic        i_pix_data_valid;
  logic [63:0] i_pix_data;
  logic        o_pix_data_ack;
  logic        o_line1_data_valid, o_line2_data_valid, o_line3_data_valid;
  logic [63:0] o_line1_data, o_line2_data, o_line3_data;
  logic        ack1, ack2, ack3;
  logic        o_frame_done;

  line_stream_gen #(.LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_pix_data_valid   (i_pix_data_valid),
    .i_pix_data         (i_pix_data),
    .o_pix_data_ack     (o_pix_data_ack),
    .o_line1_data_valid (o_line1_data_valid),
    .o_line1_data       (o_line1_data),
    .i_line1_data_ack   (ack1),
    .o_line2_data_valid (o_line2_data_valid),
    .o_line2_data       (o_line2_data),
    .i_line2_data_ack   (ack2),
    .o_line3_data_valid (o_line3_data_valid),
    .o_line3_data       (o_line3_data),
    .i_line3_data_ack   (ack3),
    .o_frame_done       (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [63:0]  mem [FL][LW];
  logic [191:0] exp_q [$];
  int           m_row, m_col;
  bit           busy, emit_pend;
  bit   [2:0]   ldone;
  logic [191:0] cur;

  // DUT-side beat observation
  bit   [2:0]   dd;
  int           dut_beats, fdones;
  logic [191:0] first_beat, last_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    busy = 0; emit_pend = 0; ldone = '0;
    exp_q.delete();
    dd = '0;
  endtask

  task automatic drive(input bit v, input bit [2:0] a);
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    i_pix_data_valid = v;
    i_pix_data = {r0, r1[23:0], 4'(m_row), 4'(m_col)};
    {ack3, ack2, ack1} = a;
  endtask

  task automatic accept_word(input logic [63:0] w);
    bit fe;
    int r1;
    mem[m_row][m_col] = w;
    fe = (m_row == FL - 1) && (m_col == LW - 1);
    chk("frame_done", 64'(o_frame_done), 64'(fe));
    if (o_frame_done) fdones++;
    if (m_row >= FILL_ROWS) begin
      r1 = (m_row >= 2) ? m_row - 2 : 0;
      exp_q.push_back({mem[r1][m_col], mem[m_row - 1][m_col], w});
      emit_pend = 1;
    end
    m_col++;
    if (m_col == LW) begin
      m_col = 0;
      m_row = (m_row == FL - 1) ? 0 : m_row + 1;
    end
  endtask

  // Called mid-cycle: compares DUT against the model, then applies this cycle's transfers.
  task automatic observe();
    logic [2:0]   acks;
    logic [191:0] obs;
    bit           exp_v, exp_pa, fin;
    acks = {ack3, ack2, ack1};
    obs  = {o_line1_data, o_line2_data, o_line3_data};
    exp_v = busy | emit_pend;
    chk("valid1", 64'(o_line1_data_valid), 64'(exp_v));
    chk("valid2", 64'(o_line2_data_valid), 64'(exp_v));
    chk("valid3", 64'(o_line3_data_valid), 64'(exp_v));
    if (emit_pend) begin
      cur = exp_q.pop_front();
      emit_pend = 0; busy = 1; ldone = '0;
      chk("beat_l1", o_line1_data, cur[191:128]);
      chk("beat_l2", o_line2_data, cur[127:64]);
      chk("beat_l3", o_line3_data, cur[63:0]);
    end else if (busy) begin
      chk("hold", 64'(obs === cur), 64'(1));
    end
    fin = 0;
    if (busy) begin
      ldone = ldone | acks;
      fin = &ldone;
    end
    exp_pa = (m_row < FILL_ROWS) || !busy || fin;
    chk("pix_ack", 64'(o_pix_data_ack), 64'(exp_pa));
    if (fin) busy = 0;
    if (o_line1_data_valid === 1'b1) begin
      dd = dd | acks;
      if (&dd) begin
        dut_beats++;
        if (dut_beats == 1) first_beat = obs;
        last_beat = obs;
        dd = '0;
      end
    end
    if (i_pix_data_valid && o_pix_data_ack) accept_word(i_pix_data);
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_pix_data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid1", 64'(o_line1_data_valid), 64'(0));
    chk("rst_valid2", 64'(o_line2_data_valid), 64'(0));
    chk("rst_valid3", 64'(o_line3_data_valid), 64'(0));
    chk("rst_data1", o_line1_data, 64'(0));
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic stream_frame(input string tag);
    dut_beats = 0; fdones = 0;
    for (int i = 0; i < LW * FL; i++) begin
      drive(1'b1, 3'b111);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b111);
      tick();
    end
    chk({tag, "_beats"}, 64'(dut_beats), 64'(BEATS_PER_FRAME));
    chk({tag, "_frame_done"}, 64'(fdones), 64'(1));
    chk({tag, "_first"}, 64'({first_beat[135:128], first_beat[71:64], first_beat[7:0]}),
        64'({FIRST_L1, FIRST_L2, FIRST_L3}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cnt;
    i_rst = 1'b1;
    i_pix_data_valid = 1'b0;
    i_pix_data = '0;
    {ack3, ack2, ack1} = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // full frame, acks held high
    stream_frame("frame1");
    chk("frame1_last", 64'({last_beat[135:128], last_beat[71:64], last_beat[7:0]}),
        64'({8'h13, 8'h23, 8'h33}));

    // skewed acks, then last ack coinciding with the next accepted word
    wait_cnt = 0;
    drive(1'b1, 3'b000);
    while (o_line1_data_valid !== 1'b1 && wait_cnt < 30) begin
      tick();
      drive(1'b1, 3'b000);
      wait_cnt++;
    end
    chk("skew_wait", 64'(o_line1_data_valid), 64'(1));
    drive(1'b1, 3'b001); tick();
    drive(1'b1, 3'b000); tick();
    drive(1'b1, 3'b100); #1;
    chk("skew_ack_t2", 64'(o_pix_data_ack), 64'(0));
    tick();
    drive(1'b1, 3'b000); tick();
    drive(1'b1, 3'b010); #1;
    chk("skew_ack_t4", 64'(o_pix_data_ack), 64'(1));
    tick();
    drive(1'b0, 3'b000);
    chk("simul_valid", 64'(o_line1_data_valid), 64'(1));
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b111);
      tick();
    end

    // randomized valids and acks over a few frames
    for (int i = 0; i < 200; i++) begin
      drive(($urandom % 4) != 0,
            {($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 7});
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b111);
      tick();
    end

    // reset with a beat pending in row 2, then a clean frame
    do_reset();
    wait_cnt = 0;
    while (!(m_row == 2 && m_col >= 1) && wait_cnt < 30) begin
      drive(1'b1, 3'b000);
      tick();
      wait_cnt++;
    end
    chk("midrst_reach", 64'(m_row == 2 && m_col >= 1), 64'(1));
    do_reset();
    stream_frame("frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
